// File: rtl/bram_stream_pkg.sv
// bram_stream_pkg: shared bank constants, mode codes, instruction layout and FSM states
package bram_stream_pkg;
    localparam int BANK_DEPTH = 12544;
    localparam logic [1:0] RMODE = 2'b01;
    localparam logic [1:0] WMODE = 2'b00;
    localparam int WEIGHT_BIT = 33;
    localparam int MODE_LSB = 30;
    localparam int ADDR_LSB = 15;
    localparam int LEN_LSB = 0;
    typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, DONE} state_t;
    function automatic logic [63:0] make_instr(input logic weight, input logic [1:0] mode,
                                               input logic [14:0] addr, input logic [14:0] len);
        logic [63:0] w;
        w = '0;
        w[WEIGHT_BIT] = weight;
        w[MODE_LSB +: 2] = mode;
        w[ADDR_LSB +: 15] = addr;
        w[LEN_LSB +: 15] = len;
        return w;
    endfunction
endpackage

// File: rtl/bram_cmd_sequencer_if.sv
// bram_cmd_sequencer_if: descriptor, instruction and monitored-tap signals of the command sequencer
interface bram_cmd_sequencer_if;
    logic desc_valid, desc_ready, desc_rd, desc_weight;
    logic [14:0] desc_addr;
    logic [15:0] desc_len;
    logic [63:0] m_instruct_tdata;
    logic m_instruct_tvalid, m_instruct_tready;
    logic mon_rd_tvalid, mon_rd_tready, mon_rd_tlast;
    logic mon_wr_tvalid, mon_wr_tready, mon_wr_tlast;
    modport master(
        input desc_valid, desc_rd, desc_weight, desc_addr, desc_len, m_instruct_tready,
        input mon_rd_tvalid, mon_rd_tready, mon_rd_tlast, mon_wr_tvalid, mon_wr_tready, mon_wr_tlast,
        output desc_ready, m_instruct_tdata, m_instruct_tvalid
    );
    modport slave(
        output desc_valid, desc_rd, desc_weight, desc_addr, desc_len, m_instruct_tready,
        output mon_rd_tvalid, mon_rd_tready, mon_rd_tlast, mon_wr_tvalid, mon_wr_tready, mon_wr_tlast,
        input desc_ready, m_instruct_tdata, m_instruct_tvalid
    );
endinterface

// File: rtl/bram_chunk_calc.sv
// bram_chunk_calc: chunk = min(remaining, MAX_BURST, room left in the low bank), plus descriptor range check
module bram_chunk_calc
    import bram_stream_pkg::*;
#(
    parameter int BANK_DEPTH = bram_stream_pkg::BANK_DEPTH,
    parameter int MAX_BURST = 4096
)(
    input  logic [14:0] addr,
    input  logic [15:0] rem,
    output logic [14:0] chunk,
    output logic        bad
);
    localparam logic [16:0] BD = 17'(BANK_DEPTH);
    localparam logic [16:0] MB = 17'(MAX_BURST);
    localparam logic [16:0] TOP = 17'(2 * BANK_DEPTH);
    logic [16:0] a, r, room, c0;
    always_comb begin
        a = {2'b0, addr};
        r = {1'b0, rem};
        room = BD - a;
        c0 = r > MB ? MB : r;
        chunk = 15'((a < BD && room < c0) ? room : c0);
        bad = rem == '0 || a + r > TOP;
    end
endmodule

// File: rtl/bram_cmd_sequencer.sv
// bram_cmd_sequencer: splits a host descriptor into bank-safe BRAM instructions, one chunk in flight at a time.
// Define CMD_WATCHDOG_EN to abort a chunk whose tlast does not arrive within WDOG_CYCLES WAIT cycles.
module bram_cmd_sequencer
    import bram_stream_pkg::*;
#(
    parameter int BANK_DEPTH = bram_stream_pkg::BANK_DEPTH,
    parameter int MAX_BURST = 4096,
    parameter logic [1:0] RMODE = bram_stream_pkg::RMODE,
    parameter logic [1:0] WMODE = bram_stream_pkg::WMODE
`ifdef CMD_WATCHDOG_EN
    , parameter int WDOG_CYCLES = 65535
`endif
)(
    input  logic                        clk,
    input  logic                        rst_n,
    bram_cmd_sequencer_if.master        bus,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [7:0]                  chunk_cnt
);
    state_t state;
    logic [14:0] addr, chunk, c_chunk;
    logic [15:0] rem;
    logic rd, weight, c_bad, tlast_ev;
`ifdef CMD_WATCHDOG_EN
    logic [15:0] wdog;
`endif
    // In IDLE the calculator sees the incoming descriptor so a bad range can flag err during CALC
    bram_chunk_calc #(.BANK_DEPTH(BANK_DEPTH), .MAX_BURST(MAX_BURST)) u_calc (
        .addr(state == IDLE ? bus.desc_addr : addr),
        .rem(state == IDLE ? bus.desc_len : rem),
        .chunk(c_chunk),
        .bad(c_bad)
    );
    assign tlast_ev = rd ? bus.mon_rd_tvalid & bus.mon_rd_tready & bus.mon_rd_tlast
                         : bus.mon_wr_tvalid & bus.mon_wr_tready & bus.mon_wr_tlast;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr <= '0;
            chunk <= '0;
            rem <= '0;
            rd <= 1'b0;
            weight <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            chunk_cnt <= '0;
            bus.desc_ready <= 1'b0;
            bus.m_instruct_tdata <= '0;
            bus.m_instruct_tvalid <= 1'b0;
`ifdef CMD_WATCHDOG_EN
            wdog <= '0;
`endif
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (bus.desc_valid && bus.desc_ready) begin
                    state <= CALC;
                    rd <= bus.desc_rd;
                    weight <= bus.desc_weight;
                    addr <= bus.desc_addr;
                    rem <= bus.desc_len;
                    chunk_cnt <= '0;
                    busy <= 1'b1;
                    bus.desc_ready <= 1'b0;
                    err <= c_bad;
                end else begin
                    bus.desc_ready <= 1'b1;
                end
                CALC: if (chunk_cnt == '0 && c_bad) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    bus.desc_ready <= 1'b1;
                end else begin
                    state <= ISSUE;
                    chunk <= c_chunk;
                    bus.m_instruct_tdata <= make_instr(weight, rd ? RMODE : WMODE, addr, c_chunk);
                    bus.m_instruct_tvalid <= 1'b1;
                end
                ISSUE: if (bus.m_instruct_tready) begin
                    state <= WAIT;
                    bus.m_instruct_tvalid <= 1'b0;
`ifdef CMD_WATCHDOG_EN
                    wdog <= '0;
`endif
                end
                WAIT: if (tlast_ev) begin
                    addr <= addr + chunk;
                    rem <= rem - {1'b0, chunk};
                    chunk_cnt <= chunk_cnt == 8'hff ? chunk_cnt : chunk_cnt + 8'd1;
                    state <= rem == {1'b0, chunk} ? DONE : CALC;
                    done <= rem == {1'b0, chunk};
                end
`ifdef CMD_WATCHDOG_EN
                else if (wdog == 16'(WDOG_CYCLES - 1)) begin
                    state <= IDLE;
                    err <= 1'b1;
                    busy <= 1'b0;
                    bus.desc_ready <= 1'b1;
                end else begin
                    wdog <= wdog + 16'd1;
                end
`endif
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    bus.desc_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_cmd_sequencer.sv
// tb_bram_cmd_sequencer: directed vectors for chunking, bank split, handshake stall, errors, reset and watchdog
module tb_bram_cmd_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, done, err;
    logic [7:0] chunk_cnt;
    int total = 0;
    int bad = 0;
    bram_cmd_sequencer_if bif();
    bram_cmd_sequencer #(
        .MAX_BURST(4096)
`ifdef CMD_WATCHDOG_EN
        , .WDOG_CYCLES(20)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bif.master),
        .busy(busy),
        .done(done),
        .err(err),
        .chunk_cnt(chunk_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask
    task automatic send_desc(input logic r, input logic w, input logic [14:0] a, input logic [15:0] l);
        bif.desc_valid = 1'b1;
        bif.desc_rd = r;
        bif.desc_weight = w;
        bif.desc_addr = a;
        bif.desc_len = l;
        @(negedge clk);
        bif.desc_valid = 1'b0;
    endtask
    task automatic take_instr(input string tag, input logic [63:0] exp, input int stall);
        int n = 0;
        while (!bif.m_instruct_tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_tvalid"}, 64'(bif.m_instruct_tvalid), 64'd1);
        chk({tag, "_tdata"}, bif.m_instruct_tdata, exp);
        repeat (stall) @(negedge clk);
        if (stall > 0) begin
            chk({tag, "_hold_valid"}, 64'(bif.m_instruct_tvalid), 64'd1);
            chk({tag, "_hold_data"}, bif.m_instruct_tdata, exp);
        end
        bif.m_instruct_tready = 1'b1;
        @(negedge clk);
        bif.m_instruct_tready = 1'b0;
        chk({tag, "_drop"}, 64'(bif.m_instruct_tvalid), 64'd0);
    endtask
    task automatic tlast(input logic r);
        {bif.mon_rd_tvalid, bif.mon_rd_tready, bif.mon_rd_tlast} = r ? 3'b111 : 3'b000;
        {bif.mon_wr_tvalid, bif.mon_wr_tready, bif.mon_wr_tlast} = r ? 3'b000 : 3'b111;
        @(negedge clk);
        {bif.mon_rd_tvalid, bif.mon_rd_tready, bif.mon_rd_tlast} = 3'b000;
        {bif.mon_wr_tvalid, bif.mon_wr_tready, bif.mon_wr_tlast} = 3'b000;
    endtask
    initial begin
        int n;
        logic seen;
        bif.desc_valid = 1'b0;
        bif.desc_rd = 1'b0;
        bif.desc_weight = 1'b0;
        bif.desc_addr = '0;
        bif.desc_len = '0;
        bif.m_instruct_tready = 1'b0;
        {bif.mon_rd_tvalid, bif.mon_rd_tready, bif.mon_rd_tlast} = 3'b000;
        {bif.mon_wr_tvalid, bif.mon_wr_tready, bif.mon_wr_tlast} = 3'b000;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tvalid", 64'(bif.m_instruct_tvalid), 64'd0);
        chk("rst_ready", 64'(bif.desc_ready), 64'd0);
        chk("rst_done_err", {62'd0, done, err}, 64'd0);
        chk("rst_cnt", 64'(chunk_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(bif.desc_ready), 64'd1);
        send_desc(1'b1, 1'b0, 15'd0, 16'd100);
        chk("t1_calc_tvalid", 64'(bif.m_instruct_tvalid), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1_latency", 64'(bif.m_instruct_tvalid), 64'd1);
        take_instr("t1", 64'h0000_0000_4000_0064, 0);
        tlast(1'b1);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_cnt", 64'(chunk_cnt), 64'd1);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_ready", 64'(bif.desc_ready), 64'd1);
        send_desc(1'b0, 1'b1, 15'd12500, 16'd100);
        take_instr("t2a", 64'h0000_0002_186A_002C, 0);
        tlast(1'b1);
        chk("t2_rd_tap_ignored", 64'(chunk_cnt), 64'd0);
        tlast(1'b0);
        chk("t2_mid_done", 64'(done), 64'd0);
        chk("t2_calc_tvalid", 64'(bif.m_instruct_tvalid), 64'd0);
        take_instr("t2b", 64'h0000_0002_1880_0038, 0);
        tlast(1'b0);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_cnt", 64'(chunk_cnt), 64'd2);
        @(negedge clk);
        send_desc(1'b1, 1'b0, 15'd0, 16'd10000);
        @(negedge clk);
        tlast(1'b1);
        take_instr("t3a", 64'h0000_0000_4000_1000, 0);
        chk("t3_issue_tlast_ignored", 64'(chunk_cnt), 64'd0);
        tlast(1'b1);
        chk("t3a_done", 64'(done), 64'd0);
        chk("t3a_cnt", 64'(chunk_cnt), 64'd1);
        take_instr("t3b", 64'h0000_0000_4800_1000, 0);
        tlast(1'b1);
        chk("t3b_done", 64'(done), 64'd0);
        chk("t3b_cnt", 64'(chunk_cnt), 64'd2);
        take_instr("t3c", 64'h0000_0000_5000_0710, 0);
        tlast(1'b1);
        chk("t3c_done", 64'(done), 64'd1);
        chk("t3c_cnt", 64'(chunk_cnt), 64'd3);
        @(negedge clk);
        send_desc(1'b1, 1'b0, 15'd25000, 16'd100);
        chk("t4_range_err", 64'(err), 64'd1);
        chk("t4_range_tvalid", 64'(bif.m_instruct_tvalid), 64'd0);
        @(negedge clk);
        chk("t4_err_pulse", 64'(err), 64'd0);
        chk("t4_ready", 64'(bif.desc_ready), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        send_desc(1'b0, 1'b0, 15'd0, 16'd0);
        chk("t4_zero_err", 64'(err), 64'd1);
        @(negedge clk);
        chk("t4_zero_ready", 64'(bif.desc_ready), 64'd1);
        chk("t4_zero_tvalid", 64'(bif.m_instruct_tvalid), 64'd0);
        send_desc(1'b1, 1'b0, 15'd25000, 16'd88);
        chk("t5_edge_no_err", 64'(err), 64'd0);
        take_instr("t5", 64'h0000_0000_70D4_0058, 5);
        chk("t5_wait_busy", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_tdata", bif.m_instruct_tdata, 64'd0);
        chk("t5_rst_ready", 64'(bif.desc_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_post_rst_ready", 64'(bif.desc_ready), 64'd1);
        send_desc(1'b1, 1'b0, 15'd0, 16'd5);
        @(negedge clk);
        chk("t5_issue_tvalid", 64'(bif.m_instruct_tvalid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", 64'(bif.m_instruct_tvalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_desc(1'b1, 1'b0, 15'd0, 16'd5);
        take_instr("t6", 64'h0000_0000_4000_0005, 0);
`ifdef CMD_WATCHDOG_EN
        n = 0;
        while (!err && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_wdog_cycles", 64'(n), 64'd20);
        @(negedge clk);
        chk("t6_wdog_idle", 64'(busy), 64'd0);
        chk("t6_wdog_ready", 64'(bif.desc_ready), 64'd1);
        chk("t6_wdog_cnt", 64'(chunk_cnt), 64'd0);
`else
        seen = 1'b0;
        n = 0;
        repeat (1000) begin
            @(negedge clk);
            seen |= err;
            n++;
        end
        chk("t6_no_err", 64'(seen), 64'd0);
        chk("t6_still_busy", 64'(busy), 64'd1);
        tlast(1'b1);
        chk("t6_done", 64'(done), 64'd1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
